seg_scan_controller: RTL and testbench

//   Time-multiplexed scan driver for the 7-segment display bank. Holds one frame of

---
 rtl/seg_scan_controller.sv | 164 ++++++++++++++++
 tb/tb_seg_scan_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_controller.sv
// seg_scan_controller: double-buffered, time-multiplexed 7-segment scan driver.
// Each digit gets GAP_CYCLES all-off cycles then PRESCALE driven cycles; new
// frames are staged in a pending buffer and committed only at frame boundaries.
// Optional blink feature: define SEG_SCAN_BLINK_EN to add the blink_mask port.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   frame_data/valid    offered frame (digit i at [i*CODE_W +: CODE_W])
//   frame_ready         pending buffer empty
//   digit_code          code of the active digit (blank in gaps)
//   digit_sel           one-hot digit enable, zero in gaps
//   scan_tick           1-cycle pulse after each frame boundary
//   blink_mask          per-digit blink enable (SEG_SCAN_BLINK_EN only)
module seg_scan_controller #(
  parameter int NUM_DIGITS   = 6,
  parameter int CODE_W       = 8,
  parameter int PRESCALE     = 10000,
  parameter int GAP_CYCLES   = 4,
  parameter int BLANK_CODE   = 34,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_DIGITS*CODE_W-1:0] frame_data,
  input  logic                         frame_valid,
  output logic                         frame_ready,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]        blink_mask,
`endif
  output logic [CODE_W-1:0]            digit_code,
  output logic [NUM_DIGITS-1:0]        digit_sel,
  output logic                         scan_tick
);

  localparam int CNT_MAX =
    (PRESCALE > GAP_CYCLES) ? PRESCALE : GAP_CYCLES;
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] PS_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CODE_W-1:0] BLANK = CODE_W'(BLANK_CODE);

  typedef enum logic {S_GAP, S_DRIVE} state_t;

  state_t                       r_state;
  logic [CW-1:0]                r_cnt;
  logic [IW-1:0]                r_idx;
  logic [CODE_W-1:0]            r_disp [NUM_DIGITS];
  logic [NUM_DIGITS*CODE_W-1:0] r_pend;
  logic                         r_ready;
  logic [CODE_W-1:0]            r_code;
  logic [NUM_DIGITS-1:0]        r_sel;
  logic                         r_tick;

  logic                  w_last;
  logic                  w_boundary;
  logic                  w_accept;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [CODE_W-1:0]     w_code;

  assign w_last     = (r_idx == IDX_LAST);
  assign w_boundary = (r_state == S_DRIVE) &&
                      (r_cnt == PS_LAST) && w_last;
  assign w_accept   = frame_valid && r_ready;
  assign w_onehot   = NUM_DIGITS'(1) << r_idx;

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BF_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] r_fcnt;
  logic          r_blink_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fcnt        <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_boundary) begin
      if (r_fcnt == BF_LAST) begin
        r_fcnt        <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_code = r_disp[r_idx];
    if (r_blink_phase && blink_mask[r_idx])
      w_code = BLANK;
  end
`else
  logic w_unused_blink;
  assign w_unused_blink = |BLINK_FRAMES;

  always_comb begin
    w_code = r_disp[r_idx];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_GAP;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_pend  <= '0;
      r_ready <= 1'b1;
      r_code  <= BLANK;
      r_sel   <= '0;
      r_tick  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++)
        r_disp[i] <= BLANK;
    end else begin
      r_tick <= 1'b0;
      unique case (r_state)
        S_GAP: begin
          if (r_cnt == GP_LAST) begin
            r_state <= S_DRIVE;
            r_cnt   <= '0;
            r_sel   <= w_onehot;
            r_code  <= w_code;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DRIVE: begin
          if (r_cnt == PS_LAST) begin
            r_state <= S_GAP;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_code  <= BLANK;
            if (w_last) begin
              r_idx  <= '0;
              r_tick <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_GAP;
      endcase
      // ready is low whenever pending is full, so an accept can never
      // coincide with a commit.
      if (w_boundary && !r_ready) begin
        for (int i = 0; i < NUM_DIGITS; i++)
          r_disp[i] <= r_pend[i*CODE_W +: CODE_W];
        r_ready <= 1'b1;
      end else if (w_accept) begin
        r_pend  <= frame_data;
        r_ready <= 1'b0;
      end
    end
  end

  assign frame_ready = r_ready;
  assign digit_code  = r_code;
  assign digit_sel   = r_sel;
  assign scan_tick   = r_tick;

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: randomized frame traffic against a frame-timing
// reference model; expected outputs are queued per cycle and checked apart.
module tb_seg_scan_controller;

  localparam int ND    = 4;
  localparam int CW    = 8;
  localparam int PS    = 3;
  localparam int GP    = 1;
  localparam int BLANK = 34;
  localparam int BF    = 2;
  localparam int SLOT  = PS + GP;
  localparam int FP    = ND * SLOT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [ND*CW-1:0] data = '0;
  logic          valid = 1'b0;
  logic          frame_ready;
  logic [ND-1:0] mask = 4'b0010;
  logic [CW-1:0] digit_code;
  logic [ND-1:0] digit_sel;
  logic          scan_tick;

  always #5 clk = ~clk;

  seg_scan_controller #(
    .NUM_DIGITS(ND), .CODE_W(CW), .PRESCALE(PS),
    .GAP_CYCLES(GP), .BLANK_CODE(BLANK), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_data(data),
    .frame_valid(valid),
    .frame_ready(frame_ready),
`ifdef SEG_SCAN_BLINK_EN
    .blink_mask(mask),
`endif
    .digit_code(digit_code),
    .digit_sel(digit_sel),
    .scan_tick(scan_tick)
  );

  typedef struct {
    int            n;
    logic [ND-1:0] sel;
    logic [CW-1:0] code;
    logic          tick;
    logic          rdy;
    bit            chk_code;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  int          m_n = 0;
  logic [CW-1:0] m_disp [ND];
  logic [ND*CW-1:0] m_pend;
  bit          m_pfull = 0;
  bit          m_acc = 0;

  bit          prod_en = 0;
  int          gap = 0;
  logic [ND*CW-1:0] fixed_q[$];

  // Model: position in the frame follows from the cycle count since reset.
  task automatic model_edge();
    exp_t e;
    int p, d;
    bit drive;
    m_acc = 0;
    if (rst) begin
      m_n = 0;
      m_pfull = 0;
      for (int i = 0; i < ND; i++) m_disp[i] = CW'(BLANK);
    end else begin
      m_n++;
      if ((m_n % FP) == 0 && m_pfull) begin
        for (int i = 0; i < ND; i++) m_disp[i] = m_pend[i*CW +: CW];
        m_pfull = 0;
      end else if (valid && !m_pfull) begin
        m_pend = data;
        m_pfull = 1;
        m_acc = 1;
      end
    end
    p = m_n % FP;
    d = p / SLOT;
    drive = (p % SLOT) >= GP;
    e.n = m_n;
    e.sel = drive ? ND'(1) << d : '0;
    e.code = drive ? m_disp[d] : CW'(BLANK);
`ifdef SEG_SCAN_BLINK_EN
    if (drive && (((m_n / FP) / BF) % 2) == 1 && mask[d])
      e.code = CW'(BLANK);
`endif
    e.tick = (m_n > 0) && (p == 0);
    e.rdy = !m_pfull;
    e.chk_code = drive || (m_n == 0);
    q.push_back(e);
  endtask

  task automatic next_frame(output logic [ND*CW-1:0] f);
    if (fixed_q.size() > 0) begin
      f = fixed_q.pop_front();
    end else begin
      for (int i = 0; i < ND; i++) f[i*CW +: CW] = CW'($urandom_range(0, 63));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    if (m_acc) begin
      valid = 0;
      gap = (fixed_q.size() > 0) ? 0 : $urandom_range(0, 24);
    end
    if (!valid) begin
      data = $urandom;
      if (prod_en && !rst) begin
        if (gap > 0) gap--;
        else begin
          valid = 1;
          next_frame(data);
        end
      end
    end
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      checks++;
      if (digit_sel !== me.sel || scan_tick !== me.tick ||
          frame_ready !== me.rdy ||
          (me.chk_code && digit_code !== me.code)) begin
        errors++;
        $display("FAIL scan n=%0d got sel=%b code=%0d tick=%b rdy=%b exp sel=%b code=%0d tick=%b rdy=%b",
                 me.n, digit_sel, digit_code, scan_tick, frame_ready,
                 me.sel, me.code, me.tick, me.rdy);
      end
    end
  end

  initial begin
    int budget;
    fixed_q.push_back(32'h08070605);
    fixed_q.push_back(32'h04030201);
    rst = 1;
    repeat (3) cyc();
    rst = 0;
    repeat (21) cyc();
    prod_en = 1;
    repeat (200) cyc();
    budget = 0;
    while (!(m_pfull && (m_n % FP) >= 2*SLOT + GP &&
             (m_n % FP) < 3*SLOT) && budget < 3000) begin
      cyc();
      budget++;
    end
    checks++;
    if (budget >= 3000) begin
      errors++;
      $display("FAIL reset_setup got no pending-full drive of digit 2 within %0d cycles", budget);
    end
    rst = 1;
    valid = 0;
    prod_en = 0;
    mask = ND'($urandom);
    cyc();
    rst = 0;
    gap = 0;
    repeat (40) cyc();
    prod_en = 1;
    repeat (800) cyc();
    prod_en = 0;
    repeat (40) cyc();
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d queued exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
